player_motion_ctrl: RTL



---
 rtl/game_pkg.sv | 27 ++
 rtl/tick_timer.sv | 28 ++
 rtl/player_motion_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the player movement blocks: motion states, button
// bit positions and a counter-width helper.
package game_pkg;

  localparam int DEFAULT_DW = 11;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_KICK  = 1;
  localparam int BTN_JUMP  = 2;
  localparam int BTN_LEFT  = 3;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    KICK   = 2'd3
  } motion_state_e;

  // Smallest width (at least 1) that can hold max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter stepped by the frame tick; saturates at zero and
// reports when it is there. Load wins over the decrement.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion controller: turns buttons into per-frame dx/dy with
// jump/fall/kick handling, gravity and kick duration/cooldown timers.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int DW         = DEFAULT_DW,
  parameter int MOVE_STEP  = 1,
  parameter int AIR_STEP   = 1,
  parameter int JUMP_V     = 5,
  parameter int GRAVITY    = 1,
  parameter int VMAX       = 5,
  parameter int KICK_TICKS = 8,
  parameter int KICK_CD    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [3:0]    sw,
  input  logic          on_ground,
  output logic [DW-1:0] dx,
  output logic [DW-1:0] dy,
  output logic          kickon,
  output logic [1:0]    state,
  output logic          upd
);

  localparam int KT_W = cnt_width(KICK_TICKS);
  localparam int CD_W = cnt_width(KICK_CD);

  if ((JUMP_V >= (1 << (DW - 1))) || (VMAX >= (1 << (DW - 1))) ||
      (MOVE_STEP >= (1 << (DW - 1))) || (AIR_STEP >= (1 << (DW - 1))) ||
      (GRAVITY < 1) || (KICK_TICKS < 1) || (KICK_CD < 0)) begin : g_param_check
    $error("player_motion_ctrl: illegal parameter combination");
  end

  motion_state_e cur_state, next_state;

  logic signed [DW-1:0] vy, vy_next;
  logic signed [DW:0]   vy_sum;
  logic signed [DW-1:0] vy_air;
  logic signed [DW-1:0] step, dx_next, dy_next;
  logic                 jump_arm, kick_arm;
  logic                 jump_fire, kick_fire, cd_load;
  logic                 kick_done, cd_zero;
  logic                 move_right, move_left;

  // The kick timer is loaded with one less than the duration so that its
  // zero flag marks the last kick frame rather than the one after it.
  tick_timer #(.W(KT_W)) u_kick_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick),
    .load     (tick & kick_fire),
    .load_val (KT_W'(KICK_TICKS - 1)),
    .zero     (kick_done)
  );

  tick_timer #(.W(CD_W)) u_cooldown (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick),
    .load     (tick & cd_load),
    .load_val (CD_W'(KICK_CD)),
    .zero     (cd_zero)
  );

  assign move_right = sw[BTN_RIGHT] & ~sw[BTN_LEFT];
  assign move_left  = sw[BTN_LEFT] & ~sw[BTN_RIGHT];

  // Airborne velocity: add gravity one bit wider, then clamp at terminal speed.
  always_comb begin
    vy_sum = {vy[DW-1], vy} + (DW+1)'(GRAVITY);
    if (vy_sum > $signed((DW+1)'(VMAX))) vy_air = DW'(VMAX);
    else                                 vy_air = vy_sum[DW-1:0];
  end

  always_comb begin
    next_state = cur_state;
    vy_next    = vy;
    jump_fire  = 1'b0;
    kick_fire  = 1'b0;
    cd_load    = 1'b0;
    case (cur_state)
      GROUND: begin
        if (sw[BTN_JUMP] && jump_arm && on_ground) begin
          next_state = RISE;
          vy_next    = DW'(-JUMP_V);
          jump_fire  = 1'b1;
        end else if (sw[BTN_KICK] && kick_arm && cd_zero) begin
          next_state = KICK;
          vy_next    = '0;
          kick_fire  = 1'b1;
        end else if (!on_ground) begin
          next_state = FALL;
          vy_next    = DW'(GRAVITY);
        end else begin
          vy_next = '0;
        end
      end
      RISE: begin
        vy_next = vy_air;
        if (!vy_air[DW-1]) next_state = FALL;
      end
      FALL: begin
        vy_next = vy_air;
        if (on_ground && !vy_air[DW-1] && (vy_air != '0)) begin
          next_state = GROUND;
          vy_next    = '0;
        end
      end
      KICK: begin
        vy_next = '0;
        if (kick_done) begin
          cd_load = 1'b1;
          if (on_ground) begin
            next_state = GROUND;
          end else begin
            next_state = FALL;
            vy_next    = DW'(GRAVITY);
          end
        end
      end
      default: next_state = GROUND;
    endcase
  end

  // Outputs describe the frame after the update, so they follow next_state.
  always_comb begin
    step    = (next_state == GROUND) ? DW'(MOVE_STEP) : DW'(AIR_STEP);
    dx_next = '0;
    if (next_state != KICK) begin
      if (move_right)     dx_next = step;
      else if (move_left) dx_next = -step;
    end
    dy_next = ((next_state == RISE) || (next_state == FALL)) ? vy_next : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= GROUND;
      vy        <= '0;
      dx        <= '0;
      dy        <= '0;
      kickon    <= 1'b0;
      upd       <= 1'b0;
      jump_arm  <= 1'b1;
      kick_arm  <= 1'b1;
    end else begin
      upd <= tick;
      if (tick) begin
        cur_state <= next_state;
        vy        <= vy_next;
        dx        <= dx_next;
        dy        <= dy_next;
        kickon    <= (next_state == KICK);
        if (jump_fire)          jump_arm <= 1'b0;
        else if (!sw[BTN_JUMP]) jump_arm <= 1'b1;
        if (kick_fire)          kick_arm <= 1'b0;
        else if (!sw[BTN_KICK]) kick_arm <= 1'b1;
      end
    end
  end

  assign state = cur_state;

endmodule
